// File: rtl/ym_phase_gen.sv
// rtl/ym_phase_gen.sv - two-phase c1/c2 enable generator with programmable divisor and slot counter
module ym_phase_gen #(
    parameter int DIV_WIDTH  = 4,
    parameter int SLOT_COUNT = 24,
    parameter int SLOT_WIDTH = 5
) (
    input  logic                  MCLK,
    input  logic                  reset,
    input  logic                  run,
    input  logic [DIV_WIDTH-1:0]  div_cfg,
    input  logic                  ext_sync,
    output logic                  c1,
    output logic                  c2,
    output logic [SLOT_WIDTH-1:0] slot,
    output logic                  slot_last,
    output logic                  frame_sync
);

    localparam int PW = DIV_WIDTH + 1;
    localparam logic [SLOT_WIDTH-1:0] SLOT_LAST = SLOT_WIDTH'(SLOT_COUNT - 1);

    logic [PW-1:0]         pc_q, pc_d;
    logic [PW-1:0]         n_act_q, n_act_d;
    logic [PW-1:0]         n_cfg, half;
    logic                  wrap, adv;
    logic                  load_q;
    logic                  sp_q, sp_d;
    logic [SLOT_WIDTH-1:0] slot_q, slot_d;
    logic                  c1_q, c1_d;
    logic                  c2_q, c2_d;
    logic                  last_q, last_d;
    logic                  fs_q, fs_d;

    always_comb begin
        n_cfg = PW'(div_cfg) + PW'(2);
        half  = n_act_q >> 1;
        wrap  = (pc_q == n_act_q - PW'(1));
        adv   = run & (pc_q == half);

        pc_d = pc_q;
        if (run) begin
            pc_d = wrap ? '0 : pc_q + PW'(1);
        end

        // Divisor only changes on a period boundary so a running period is never stretched mid-way.
        n_act_d = n_act_q;
        if (load_q || (run && wrap)) begin
            n_act_d = n_cfg;
        end

        slot_d = slot_q;
        if (adv) begin
            if (sp_q || (slot_q == SLOT_LAST)) begin
                slot_d = '0;
            end else begin
                slot_d = slot_q + SLOT_WIDTH'(1);
            end
        end

        // A resync request arriving on the consuming edge survives for the following advance.
        sp_d   = ext_sync | (sp_q & ~adv);
        c1_d   = run & (pc_q == '0);
        c2_d   = adv;
        fs_d   = c1_d & (slot_q == '0);
        last_d = (slot_d == SLOT_LAST);
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            pc_q    <= '0;
            n_act_q <= PW'(2);
            load_q  <= 1'b1;
            sp_q    <= 1'b0;
            slot_q  <= '0;
            c1_q    <= 1'b0;
            c2_q    <= 1'b0;
            last_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            n_act_q <= n_act_d;
            load_q  <= 1'b0;
            sp_q    <= sp_d;
            slot_q  <= slot_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            last_q  <= last_d;
            fs_q    <= fs_d;
        end
    end

    assign c1         = c1_q;
    assign c2         = c2_q;
    assign slot       = slot_q;
    assign slot_last  = last_q;
    assign frame_sync = fs_q;

endmodule

// File: tb/tb_ym_phase_gen.sv
// tb/tb_ym_phase_gen.sv - self-checking bench for ym_phase_gen
module tb_ym_phase_gen;

    localparam int DW = 4;
    localparam int SC = 24;
    localparam int SW = 5;

    logic          MCLK = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic [DW-1:0] div_cfg = '0;
    logic          ext_sync = 1'b0;
    logic          c1, c2, slot_last, frame_sync;
    logic [SW-1:0] slot;

    int checks = 0;
    int errors = 0;

    // reference model: integer phase/period/slot bookkeeping
    int            m_pc = 0, m_n = 2, m_slot = 0;
    bit            m_sp = 0, m_fresh = 1;
    logic          e_c1, e_c2, e_last, e_fs;
    logic [SW-1:0] e_slot;

    ym_phase_gen #(.DIV_WIDTH(DW), .SLOT_COUNT(SC), .SLOT_WIDTH(SW)) dut (
        .MCLK(MCLK), .reset(reset), .run(run), .div_cfg(div_cfg), .ext_sync(ext_sync),
        .c1(c1), .c2(c2), .slot(slot), .slot_last(slot_last), .frame_sync(frame_sync)
    );

    always #5 MCLK = ~MCLK;

    task automatic tick();
        bit adv;
        if (reset) begin
            {e_c1, e_c2, e_last, e_fs} = 4'b0;
            e_slot = '0;
            m_pc = 0; m_n = 2; m_slot = 0; m_sp = 0; m_fresh = 1;
        end else begin
            adv  = run && (m_pc == m_n / 2);
            e_c1 = run && (m_pc == 0);
            e_c2 = adv;
            e_fs = e_c1 && (m_slot == 0);
            if (adv) m_slot = m_sp ? 0 : (m_slot + 1) % SC;
            e_slot = SW'(m_slot);
            e_last = (m_slot == SC - 1);
            m_sp = ext_sync || (m_sp && !adv);
            if (run) begin
                if (m_pc == m_n - 1) begin
                    m_pc = 0;
                    m_n  = int'(div_cfg) + 2;
                end else begin
                    m_pc++;
                end
            end
            if (m_fresh) begin
                m_n = int'(div_cfg) + 2;
                m_fresh = 0;
            end
        end
        @(posedge MCLK);
        #1;
    endtask

    task automatic restart(input int cfg);
        reset = 1'b1; run = 1'b1; ext_sync = 1'b0; div_cfg = DW'(cfg);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b1; div_cfg = DW'(2);
        tick(); tick();
        checks++;
        if ({c1, c2, slot_last, frame_sync} !== 4'b0 || slot !== '0) begin
            errors++;
            $display("FAIL reset: c1=%b c2=%b slot=%0d last=%b fs=%b required all 0", c1, c2, slot, slot_last, frame_sync);
        end
    endtask

    task automatic test_div4();
        restart(2);
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if (c1 !== (k % 4 == 0) || c2 !== (k % 4 == 2)) begin
                errors++;
                $display("FAIL div4 cycle %0d: c1=%b c2=%b required c1=%b c2=%b", k, c1, c2, k % 4 == 0, k % 4 == 2);
            end
        end
    endtask

    task automatic test_div_change();
        logic ec1, ec2;
        restart(1);
        for (int k = 0; k < 18; k++) begin
            if (k == 5) div_cfg = DW'(4);
            tick();
            ec1 = (k == 0 || k == 3 || k == 6 || k == 12);
            ec2 = (k == 1 || k == 4 || k == 9 || k == 15);
            checks++;
            if (c1 !== ec1 || c2 !== ec2) begin
                errors++;
                $display("FAIL div_change cycle %0d: c1=%b c2=%b required c1=%b c2=%b", k, c1, c2, ec1, ec2);
            end
        end
    endtask

    task automatic test_slot_wrap();
        int n = 0;
        bit done = 0;
        restart(0);
        for (int k = 0; k < 120 && !done; k++) begin
            tick();
            if (c2) begin
                n++;
                checks++;
                if (slot !== SW'(n % SC) || slot_last !== (n % SC == SC - 1)) begin
                    errors++;
                    $display("FAIL slot_wrap c2 #%0d: slot=%0d last=%b required slot=%0d last=%b", n, slot, slot_last, n % SC, n % SC == SC - 1);
                end
            end
            if (c1) begin
                checks++;
                if (frame_sync !== (n % SC == 0)) begin
                    errors++;
                    $display("FAIL slot_wrap frame_sync after %0d c2: got %b required %b", n, frame_sync, n % SC == 0);
                end
                if (n == SC) done = 1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL slot_wrap timeout: c2 count=%0d required %0d plus a c1", n, SC);
        end
    endtask

    task automatic test_ext_sync();
        int n = 0;
        bit found = 0;
        restart(2);
        for (int k = 0; k < 200 && !found; k++) begin
            tick();
            if (c2) begin
                n++;
                if (n == 10) found = 1;
            end
        end
        checks++;
        if (!found || slot !== SW'(10)) begin
            errors++;
            $display("FAIL ext_sync setup: found=%b slot=%0d required slot=10", found, slot);
        end
        tick();
        ext_sync = 1'b1;
        tick();
        ext_sync = 1'b0;
        found = 0;
        for (int k = 0; k < 8 && !found; k++) begin
            tick();
            if (c2) found = 1;
            else begin
                checks++;
                if (slot !== SW'(10)) begin
                    errors++;
                    $display("FAIL ext_sync hold: slot=%0d required 10", slot);
                end
            end
        end
        checks++;
        if (!found || slot !== '0) begin
            errors++;
            $display("FAIL ext_sync realign: found=%b slot=%0d required 0", found, slot);
        end
        found = 0;
        for (int k = 0; k < 8 && !found; k++) begin
            tick();
            if (c2) found = 1;
        end
        checks++;
        if (!found || slot !== SW'(1)) begin
            errors++;
            $display("FAIL ext_sync post-realign: found=%b slot=%0d required 1", found, slot);
        end
        ext_sync = 1'b1; tick();
        ext_sync = 1'b0; tick();
        ext_sync = 1'b1; tick();
        ext_sync = 1'b0; tick();
        checks++;
        if (c2 !== 1'b1 || slot !== '0) begin
            errors++;
            $display("FAIL ext_sync double pulse: c2=%b slot=%0d required c2=1 slot=0", c2, slot);
        end
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (c2 !== 1'b1 || slot !== SW'(1)) begin
            errors++;
            $display("FAIL ext_sync single realign: c2=%b slot=%0d required c2=1 slot=1", c2, slot);
        end
    endtask

    task automatic test_run_pause();
        restart(2);
        for (int k = 0; k < 5; k++) tick();
        run = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (c1 !== 1'b0 || c2 !== 1'b0 || slot !== SW'(1)) begin
                errors++;
                $display("FAIL run_pause hold %0d: c1=%b c2=%b slot=%0d required 0 0 1", k, c1, c2, slot);
            end
        end
        run = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (c1 !== (k == 4) || c2 !== (k == 2 || k == 6)) begin
                errors++;
                $display("FAIL run_pause resume %0d: c1=%b c2=%b required c1=%b c2=%b", k, c1, c2, k == 4, k == 2 || k == 6);
            end
            if (k == 2 || k == 6) begin
                checks++;
                if (slot !== SW'(k == 2 ? 2 : 3)) begin
                    errors++;
                    $display("FAIL run_pause slot %0d: slot=%0d required %0d", k, slot, k == 2 ? 2 : 3);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        restart(2);
        tick(); tick();
        reset = 1'b1;
        div_cfg = DW'(1);
        tick();
        checks++;
        if ({c1, c2, slot_last, frame_sync} !== 4'b0 || slot !== '0) begin
            errors++;
            $display("FAIL reset_mid abort: c1=%b c2=%b slot=%0d required 0 0 0", c1, c2, slot);
        end
        reset = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (c1 !== (k % 3 == 0) || c2 !== (k % 3 == 1) || (k == 0 && frame_sync !== 1'b1)) begin
                errors++;
                $display("FAIL reset_mid restart cycle %0d: c1=%b c2=%b fs=%b required c1=%b c2=%b", k, c1, c2, frame_sync, k % 3 == 0, k % 3 == 1);
            end
        end
    endtask

    task automatic test_random();
        restart(int'($urandom_range(0, 15)));
        for (int k = 0; k < 3000; k++) begin
            reset    = ($urandom_range(0, 299) == 0);
            run      = ($urandom_range(0, 9) != 0);
            ext_sync = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) div_cfg = DW'($urandom);
            tick();
            checks++;
            if ({c1, c2, slot, slot_last, frame_sync} !== {e_c1, e_c2, e_slot, e_last, e_fs} || (c1 && c2)) begin
                errors++;
                $display("FAIL random cycle %0d: c1=%b c2=%b slot=%0d last=%b fs=%b required %b %b %0d %b %b",
                         k, c1, c2, slot, slot_last, frame_sync, e_c1, e_c2, e_slot, e_last, e_fs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_div4();
        test_div_change();
        test_slot_wrap();
        test_ext_sync();
        test_run_pause();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
